// File: rtl/ecc_secded_rx_decoder.sv
// Receive-side SECDED Hamming(13,8) decoder with a 2-stage valid/ready pipeline.
// Ports:
//   clk, rst (sync, active-high)
//   in_codeword/in_valid/in_ready  : codeword input (bit i = Hamming position i)
//   out_data/out_corrected/out_uncorr/out_syndrome/out_valid/out_ready : result output
//   cnt_clr, corr_count, uncorr_count : saturating error event counters
module ecc_secded_rx_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      in_codeword,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_corrected,
    output logic             out_uncorr,
    output logic [3:0]       out_syndrome,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    logic [12:0] s1_cw;
    logic [3:0]  s1_syn;
    logic        s1_par;
    logic        s1_valid;

    logic [3:0]  syn_c;
    logic        par_c;
    logic        s2_adv;

    logic [12:0] fix_cw;
    logic [7:0]  data_c;
    logic        corr_c;
    logic        uncorr_c;
    logic        out_xfer;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        syn_c[0] = in_codeword[1] ^ in_codeword[3] ^ in_codeword[5]
                 ^ in_codeword[7] ^ in_codeword[9] ^ in_codeword[11];
        syn_c[1] = in_codeword[2] ^ in_codeword[3] ^ in_codeword[6]
                 ^ in_codeword[7] ^ in_codeword[10] ^ in_codeword[11];
        syn_c[2] = in_codeword[4] ^ in_codeword[5] ^ in_codeword[6]
                 ^ in_codeword[7] ^ in_codeword[12];
        syn_c[3] = in_codeword[8] ^ in_codeword[9] ^ in_codeword[10]
                 ^ in_codeword[11] ^ in_codeword[12];
        par_c    = ^in_codeword;
    end

    // Odd overall parity with a syndrome inside the codeword is a single
    // error; syndrome 0 means bit 0 itself flipped, so nothing to repair.
    always_comb begin
        corr_c   = s1_par && (s1_syn <= 4'd12);
        uncorr_c = (s1_par && (s1_syn > 4'd12))
                || (!s1_par && (s1_syn != 4'd0));
        fix_cw   = s1_cw;
        if (corr_c && (s1_syn != 4'd0))
            fix_cw = s1_cw ^ (13'd1 << s1_syn);
        data_c   = {fix_cw[12], fix_cw[11], fix_cw[10], fix_cw[9],
                    fix_cw[7], fix_cw[6], fix_cw[5], fix_cw[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= in_codeword;
                s1_syn <= syn_c;
                s1_par <= par_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_uncorr    <= 1'b0;
            out_syndrome  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= data_c;
                out_corrected <= corr_c;
                out_uncorr    <= uncorr_c;
                out_syndrome  <= s1_syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_xfer) begin
            if (out_corrected && (corr_count != '1))
                corr_count <= corr_count + 1'b1;
            if (out_uncorr && (uncorr_count != '1))
                uncorr_count <= uncorr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_secded_rx_decoder.sv
// Directed self-checking bench for ecc_secded_rx_decoder.
// Uses CNT_W=4 so counter saturation is reachable quickly.
module tb_ecc_secded_rx_decoder;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [12:0]      in_codeword;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_corrected;
    logic             out_uncorr;
    logic [3:0]       out_syndrome;
    logic             out_valid;
    logic             out_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;

    int tests = 0;
    int fails = 0;

    ecc_secded_rx_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_codeword  (in_codeword),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_corrected(out_corrected),
        .out_uncorr   (out_uncorr),
        .out_syndrome (out_syndrome),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cnt_clr      (cnt_clr),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d,
                           input logic c, input logic u,
                           input logic [3:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, 32'(out_data), 32'(d));
        chk({tag, ".corr"}, 32'(out_corrected), 32'(c));
        chk({tag, ".uncorr"}, 32'(out_uncorr), 32'(u));
        chk({tag, ".syn"}, 32'(out_syndrome), 32'(s));
    endtask

    task automatic send(input logic [12:0] cw);
        in_codeword = cw;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        in_codeword = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.corr_cnt", 32'(corr_count), 32'd0);
        chk("rst.uncorr_cnt", 32'(uncorr_count), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // clean word
        send(13'h14B1);
        chk_out("t1", 8'hAA, 1'b0, 1'b0, 4'd0);
        tick();
        chk("t1.drain", 32'(out_valid), 32'd0);
        chk("t1.corr_cnt", 32'(corr_count), 32'd0);

        // single error at position 6
        send(13'h14F1);
        chk_out("t2", 8'hAA, 1'b1, 1'b0, 4'd6);
        tick();
        chk("t2.corr_cnt", 32'(corr_count), 32'd1);

        // overall parity bit flipped
        send(13'h14B0);
        chk_out("t3a", 8'hAA, 1'b1, 1'b0, 4'd0);
        tick();
        chk("t3a.corr_cnt", 32'(corr_count), 32'd2);

        // double error at positions 6 and 3: raw data bits returned
        send(13'h14F9);
        chk_out("t3b", 8'hAF, 1'b0, 1'b1, 4'd5);
        tick();
        chk("t3b.uncorr_cnt", 32'(uncorr_count), 32'd1);
        chk("t3b.corr_cnt", 32'(corr_count), 32'd2);

        // triple error at 1,4,8: odd parity, syndrome 13 is out of range
        send(13'h15A3);
        chk_out("t3c", 8'hAA, 1'b0, 1'b1, 4'd13);
        tick();
        chk("t3c.uncorr_cnt", 32'(uncorr_count), 32'd2);

        // back-to-back burst with a 3-cycle stall
        in_valid    = 1'b1;
        in_codeword = 13'h0000;
        tick();
        in_codeword = 13'h14B1;
        tick();
        out_ready   = 1'b0;
        in_codeword = 13'h14F1;
        #1;
        chk("t4.in_ready_full", 32'(in_ready), 32'd0);
        chk_out("t4.w0", 8'h00, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4.hold_rdy", 32'(in_ready), 32'd0);
            chk_out("t4.hold", 8'h00, 1'b0, 1'b0, 4'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4.in_ready_go", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("t4.w1", 8'hAA, 1'b0, 1'b0, 4'd0);
        tick();
        chk_out("t4.w2", 8'hAA, 1'b1, 1'b0, 4'd6);
        tick();
        chk("t4.drain", 32'(out_valid), 32'd0);
        chk("t4.corr_cnt", 32'(corr_count), 32'd3);
        tick();
        chk("t4.no_dup", 32'(out_valid), 32'd0);

        // saturation
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5.clr_corr", 32'(corr_count), 32'd0);
        chk("t5.clr_uncorr", 32'(uncorr_count), 32'd0);
        in_codeword = 13'h14F1;
        in_valid    = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5.sat", 32'(corr_count), 32'd15);
        chk("t5.sat_drain", 32'(out_valid), 32'd0);

        // clear beats a same-cycle increment
        send(13'h14F1);
        chk_out("t5.pre_clr", 8'hAA, 1'b1, 1'b0, 4'd6);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5.clr_prio", 32'(corr_count), 32'd0);
        chk("t5.clr_xfer", 32'(out_valid), 32'd0);

        // mid-stream reset with two words in flight
        in_valid    = 1'b1;
        in_codeword = 13'h14B1;
        tick();
        in_codeword = 13'h14F1;
        tick();
        chk("t6.inflight", 32'(out_valid), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6.out_valid", 32'(out_valid), 32'd0);
        chk("t6.out_data", 32'(out_data), 32'd0);
        chk("t6.corr_cnt", 32'(corr_count), 32'd0);
        chk("t6.uncorr_cnt", 32'(uncorr_count), 32'd0);
        chk("t6.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t6.stale1", 32'(out_valid), 32'd0);
        tick();
        chk("t6.stale2", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
